// File: rtl/team_06_echo_buffer.sv
// Echo/delay buffer: records samples into a packed SRAM ring through a request/busy
// bus manager and replays them a clamped number of samples later. Optional mixer: TEAM_06_ECHO_MIX_EN.
module team_06_echo_buffer #(
   parameter int unsigned SAMPLE_W      = 8,
   parameter int unsigned DEPTH_SAMPLES = 4096,
   parameter logic [31:0] BASE_ADDR     = 32'h3300_0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   input  logic                record,
   input  logic [11:0]         offset,
   output logic [SAMPLE_W-1:0] audio_out,
   output logic                out_valid,
   output logic                overrun,
   output logic [31:0]         bus_wdata,
   output logic [31:0]         bus_adr,
   output logic [3:0]          bus_sel,
   output logic                bus_write,
   output logic                bus_read,
   input  logic                bus_busy,
   input  logic [31:0]         bus_rdata
);
   localparam int unsigned SPW      = 32 / SAMPLE_W;
   localparam int unsigned BPS      = SAMPLE_W / 8;
   localparam int unsigned LANE_W   = $clog2(SPW);
   localparam int unsigned PTR_W    = $clog2(DEPTH_SAMPLES);
   localparam int unsigned FILL_W   = PTR_W + 1;
   localparam int unsigned DEPTH_M1 = DEPTH_SAMPLES - 1;
   localparam logic [3:0]  LANE_MASK = 4'((1 << BPS) - 1);
   localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR_REQ, ST_WR_WAIT, ST_RD_REQ, ST_RD_WAIT, ST_OUT
   } state_e;

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic [PTR_W-1:0]    rd_idx_q, rd_idx_d;
   logic                skip_rd_q, skip_rd_d;
   logic [SAMPLE_W-1:0] delayed_q, delayed_d;
   logic [SAMPLE_W-1:0] audio_out_q, audio_out_d;
   logic                out_valid_q, out_valid_d;
   logic                overrun_q, overrun_d;
   logic [31:0]         bus_adr_q, bus_adr_d;
   logic [3:0]          bus_sel_q, bus_sel_d;
   logic                bus_write_q, bus_write_d;
   logic                bus_read_q, bus_read_d;

   logic [PTR_W-1:0]    eff_off_c;
   logic [PTR_W-1:0]    rd_idx_c;
   logic                skip_c;
   logic [SAMPLE_W-1:0] rd_lane_c;
   logic [SAMPLE_W-1:0] result_c;

   function automatic logic [31:0] word_adr(input logic [PTR_W-1:0] idx);
      return BASE_ADDR + ((32'(idx) >> LANE_W) << 2);
   endfunction

   function automatic logic [3:0] lane_sel(input logic [PTR_W-1:0] idx);
      return LANE_MASK << (32'(idx[LANE_W-1:0]) * BPS);
   endfunction

   // Requested delay clamped to 1..DEPTH_SAMPLES-1
   always_comb begin
      if (offset == '0) begin
         eff_off_c = PTR_W'(1);
      end else if (32'(offset) > DEPTH_M1) begin
         eff_off_c = PTR_W'(DEPTH_M1);
      end else begin
         eff_off_c = PTR_W'(offset);
      end
   end

   // Read index and the not-enough-history decision use the pre-write pointer and fill
   assign rd_idx_c  = wr_ptr_q - eff_off_c;
   assign skip_c    = fill_q < FILL_W'(eff_off_c);
   assign rd_lane_c = SAMPLE_W'(bus_rdata >> (32'(rd_idx_q[LANE_W-1:0]) * SAMPLE_W));

`ifdef TEAM_06_ECHO_MIX_EN
   localparam int unsigned SUM_W = SAMPLE_W + 2;
   logic signed [SUM_W-1:0] mix_sum_c;

   always_comb begin
      mix_sum_c = $signed({2'b00, sample_q}) + $signed({2'b00, delayed_q})
                - $signed({2'b00, MID});
      if (mix_sum_c[SUM_W-1]) begin
         result_c = '0;
      end else if (mix_sum_c[SAMPLE_W]) begin
         result_c = '1;
      end else begin
         result_c = mix_sum_c[SAMPLE_W-1:0];
      end
   end
`else
   assign result_c = delayed_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         sample_q    <= '0;
         rd_idx_q    <= '0;
         skip_rd_q   <= 1'b0;
         delayed_q   <= MID;
         audio_out_q <= MID;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         bus_adr_q   <= '0;
         bus_sel_q   <= '0;
         bus_write_q <= 1'b0;
         bus_read_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         fill_q      <= fill_d;
         sample_q    <= sample_d;
         rd_idx_q    <= rd_idx_d;
         skip_rd_q   <= skip_rd_d;
         delayed_q   <= delayed_d;
         audio_out_q <= audio_out_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
         bus_adr_q   <= bus_adr_d;
         bus_sel_q   <= bus_sel_d;
         bus_write_q <= bus_write_d;
         bus_read_q  <= bus_read_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      fill_d      = fill_q;
      sample_d    = sample_q;
      rd_idx_d    = rd_idx_q;
      skip_rd_d   = skip_rd_q;
      delayed_d   = delayed_q;
      audio_out_d = audio_out_q;
      out_valid_d = 1'b0;
      overrun_d   = overrun_q | (sample_valid && (state_q != ST_IDLE));
      bus_adr_d   = bus_adr_q;
      bus_sel_d   = bus_sel_q;
      bus_write_d = bus_write_q;
      bus_read_d  = bus_read_q;

      unique case (state_q)
         ST_IDLE: begin
            if (sample_valid) begin
               sample_d  = sample_in;
               rd_idx_d  = rd_idx_c;
               skip_rd_d = skip_c;
               if (record) begin
                  state_d     = ST_WR_REQ;
                  bus_write_d = 1'b1;
                  bus_adr_d   = word_adr(wr_ptr_q);
                  bus_sel_d   = lane_sel(wr_ptr_q);
               end else if (skip_c) begin
                  state_d   = ST_OUT;
                  delayed_d = MID;
               end else begin
                  state_d    = ST_RD_REQ;
                  bus_read_d = 1'b1;
                  bus_adr_d  = word_adr(rd_idx_c);
                  bus_sel_d  = 4'hF;
               end
            end
         end
         ST_WR_REQ: begin
            if (bus_busy) begin
               bus_write_d = 1'b0;
               state_d     = ST_WR_WAIT;
            end
         end
         ST_WR_WAIT: begin
            if (!bus_busy) begin
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
               if (fill_q != FILL_W'(DEPTH_SAMPLES)) begin
                  fill_d = fill_q + FILL_W'(1);
               end
               if (skip_rd_q) begin
                  state_d   = ST_OUT;
                  delayed_d = MID;
               end else begin
                  state_d    = ST_RD_REQ;
                  bus_read_d = 1'b1;
                  bus_adr_d  = word_adr(rd_idx_q);
                  bus_sel_d  = 4'hF;
               end
            end
         end
         ST_RD_REQ: begin
            if (bus_busy) begin
               bus_read_d = 1'b0;
               state_d    = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (!bus_busy) begin
               delayed_d = rd_lane_c;
               state_d   = ST_OUT;
            end
         end
         ST_OUT: begin
            audio_out_d = result_c;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Write data is the latched sample on every lane; the select picks the lane
   assign bus_wdata = {SPW{sample_q}};
   assign bus_adr   = bus_adr_q;
   assign bus_sel   = bus_sel_q;
   assign bus_write = bus_write_q;
   assign bus_read  = bus_read_q;
   assign audio_out = audio_out_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_team_06_echo_buffer.sv
// Self-checking bench for team_06_echo_buffer (SAMPLE_W=8, DEPTH_SAMPLES=8) with a
// request/busy SRAM manager model and a sample-level reference model of the echo ring.
`timescale 1ns/1ps
module tb_team_06_echo_buffer;
   localparam int          SW    = 8;
   localparam int          DEPTH = 8;
   localparam logic [31:0] BASE  = 32'h3300_0000;
   localparam int          MID   = 128;

   logic          clk          = 1'b0;
   logic          rst          = 1'b1;
   logic [SW-1:0] sample_in    = '0;
   logic          sample_valid = 1'b0;
   logic          record       = 1'b0;
   logic [11:0]   offset       = '0;
   logic [SW-1:0] audio_out;
   logic          out_valid;
   logic          overrun;
   logic [31:0]   bus_wdata;
   logic [31:0]   bus_adr;
   logic [3:0]    bus_sel;
   logic          bus_write;
   logic          bus_read;
   logic          bus_busy     = 1'b0;
   logic [31:0]   bus_rdata    = '0;

   int errors = 0;
   int checks = 0;

   team_06_echo_buffer #(
      .SAMPLE_W(SW), .DEPTH_SAMPLES(DEPTH), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .record(record), .offset(offset), .audio_out(audio_out), .out_valid(out_valid),
      .overrun(overrun), .bus_wdata(bus_wdata), .bus_adr(bus_adr), .bus_sel(bus_sel),
      .bus_write(bus_write), .bus_read(bus_read), .bus_busy(bus_busy), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   // Reference model: ring of samples, write pointer and saturating fill count
   int ring [DEPTH];
   int m_wr   = 0;
   int m_fill = 0;
   int exp_q [$];
   int n_out    = 0;
   int last_out = 0;

   function automatic int model_step(input int s, input int off, input bit rec);
      int eff;
      int d;
      int r;
      eff = (off == 0) ? 1 : ((off > DEPTH - 1) ? DEPTH - 1 : off);
      d   = (m_fill < eff) ? MID : ring[(m_wr - eff + DEPTH) % DEPTH];
      if (rec) begin
         ring[m_wr] = s;
         m_wr = (m_wr + 1) % DEPTH;
         if (m_fill < DEPTH) m_fill++;
      end
`ifdef TEAM_06_ECHO_MIX_EN
      r = s + d - MID;
      if (r < 0)   r = 0;
      if (r > 255) r = 255;
`else
      r = d;
`endif
      return r;
   endfunction

   // Manager model: accepts a request when idle, stays busy for 'lat' cycles
   logic [31:0] mem [2];
   int          mgr_cnt = 0;
   int          lat     = 1;
   int          wr_cnt  = 0;
   int          rd_cnt  = 0;
   logic [31:0] last_adr   = '0;
   logic [31:0] last_wdata = '0;
   logic [3:0]  last_sel   = '0;
   logic [31:0] lane_mask;
   logic        word_sel;

   assign lane_mask = {{8{bus_sel[3]}}, {8{bus_sel[2]}}, {8{bus_sel[1]}}, {8{bus_sel[0]}}};
   assign word_sel  = bus_adr[2];

   always @(posedge clk) begin
      if (mgr_cnt != 0) begin
         mgr_cnt <= mgr_cnt - 1;
         if (mgr_cnt == 1) bus_busy <= 1'b0;
      end else if (bus_write || bus_read) begin
         check("bus_adr_in_ring", longint'((bus_adr & ~32'h4) == BASE), 1);
         mgr_cnt  <= lat;
         bus_busy <= 1'b1;
         if (bus_write) begin
            wr_cnt         <= wr_cnt + 1;
            last_adr       <= bus_adr;
            last_sel       <= bus_sel;
            last_wdata     <= bus_wdata;
            mem[word_sel]  <= (mem[word_sel] & ~lane_mask) | (bus_wdata & lane_mask);
         end else begin
            rd_cnt    <= rd_cnt + 1;
            bus_rdata <= mem[word_sel];
         end
      end
   end

   // Compare process: every out_valid is checked against the model queue
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_write || bus_read) check("bus_write_read_exclusive", longint'(bus_write && bus_read), 0);
         if (out_valid) begin
            n_out++;
            last_out = int'(audio_out);
            check("out_valid_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("audio_out_model", longint'(audio_out), longint'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic clear_model();
      m_wr   = 0;
      m_fill = 0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      sample_valid = 1'b0;
      tick(2);
      #1 rst = 1'b0;
      clear_model();
   endtask

   task automatic pulse(input int s, input int off, input bit rec);
      @(posedge clk);
      #1;
      sample_in    = SW'(s);
      offset       = 12'(off);
      record       = rec;
      sample_valid = 1'b1;
      exp_q.push_back(model_step(s, off, rec));
      @(posedge clk);
      #1 sample_valid = 1'b0;
   endtask

   task automatic drop_pulse(input int s);
      @(posedge clk);
      #1;
      sample_in    = SW'(s);
      sample_valid = 1'b1;
      @(posedge clk);
      #1 sample_valid = 1'b0;
   endtask

   task automatic wait_out(input int start, output int got);
      int w;
      w = 0;
      while (n_out == start && w < 200) begin
         @(posedge clk);
         w++;
      end
      check("out_valid_arrived", longint'(n_out != start), 1);
      got = last_out;
   endtask

   task automatic send(input int s, input int off, input bit rec, output int got);
      int start;
      start = n_out;
      pulse(s, off, rec);
      wait_out(start, got);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g;
      int start;
      int w;
      int w0;
      int r0;
      int samp1 [5];
      int exp1  [5];
      mem[0] = '0;
      mem[1] = '0;
      samp1 = '{10, 20, 30, 40, 50};
`ifdef TEAM_06_ECHO_MIX_EN
      exp1 = '{10, 20, 30, 0, 0};
`else
      exp1 = '{128, 128, 128, 10, 20};
`endif

      // Reset state
      tick(3);
      #1;
      check("rst_audio_out", longint'(audio_out), MID);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_overrun", longint'(overrun), 0);
      check("rst_bus_write", longint'(bus_write), 0);
      check("rst_bus_read", longint'(bus_read), 0);
      check("rst_bus_adr", longint'(bus_adr), 0);
      check("rst_bus_sel", longint'(bus_sel), 0);
      check("rst_bus_wdata", longint'(bus_wdata), 0);
      rst = 1'b0;
      clear_model();

      // Offset 3 with recording: three midscale outputs, then the history
      lat = 2;
      for (int i = 0; i < 5; i++) begin
         send(samp1[i], 3, 1'b1, g);
         check($sformatf("offset3_out%0d", i), g, exp1[i]);
      end
      check("fifth_write_adr", longint'(last_adr), longint'(BASE + 32'd4));
      check("fifth_write_sel", longint'(last_sel), 1);
      check("fifth_write_wdata", longint'(last_wdata), 32'h3232_3232);

      // Wrap: nine writes into an 8-deep ring overwrite word 0 lane 0
      do_reset();
      for (int i = 1; i <= 9; i++) send(i, 1, 1'b1, g);
      check("wrap_word0_lane0", longint'(mem[0] & 32'hFF), 9);
      send(10, 1, 1'b1, g);
      check("wrap_next_adr", longint'(last_adr), longint'(BASE));
      check("wrap_next_sel", longint'(last_sel), 2);

      // Offset clamping with frozen loop (record low, no writes)
      w0 = wr_cnt;
      send(128, 0, 1'b0, g);
      check("offset0_as_1", g, 10);
      send(128, 4095, 1'b0, g);
      check("offset4095_as_7", g, 4);
      send(128, 7, 1'b0, g);
      check("offset7", g, 4);
      check("frozen_no_writes", wr_cnt, w0);

      // Second strobe while the manager is busy is dropped
      do_reset();
      check("overrun_clear", longint'(overrun), 0);
      lat = 5;
      start = n_out;
      pulse(55, 1, 1'b1);
      tick(2);
      drop_pulse(99);
      wait_out(start, g);
      tick(20);
      check("one_out_valid", n_out - start, 1);
      check("overrun_set", longint'(overrun), 1);
      send(128, 1, 1'b0, g);
      check("dropped_not_written", g, 55);

      // Randomised traffic against the model
      do_reset();
      for (int i = 0; i < 300; i++) begin
         lat = int'($urandom_range(1, 4));
         send(int'($urandom_range(0, 255)),
              (($urandom % 8) == 0) ? 4095 : int'($urandom_range(0, 10)),
              ($urandom % 4) != 0, g);
      end

      // Mixer saturation corner (plain echo without the mixer)
      do_reset();
      lat = 1;
      send(200, 1, 1'b1, g);
      send(200, 1, 1'b1, g);
`ifdef TEAM_06_ECHO_MIX_EN
      check("mix_saturate", g, 255);
`else
      check("echo_200", g, 200);
`endif

      // Reset during RD_WAIT abandons the transaction
      lat = 6;
      r0 = rd_cnt;
      start = n_out;
      pulse(77, 1, 1'b1);
      w = 0;
      while (rd_cnt == r0 && w < 100) begin
         @(posedge clk);
         w++;
      end
      check("read_issued", longint'(rd_cnt != r0), 1);
      tick(1);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      clear_model();
      check("rst_mid_bus_read", longint'(bus_read), 0);
      check("rst_mid_bus_write", longint'(bus_write), 0);
      tick(15);
      check("rst_mid_no_out_valid", n_out - start, 0);
      w = 0;
      while (mgr_cnt != 0 && w < 50) begin
         @(posedge clk);
         w++;
      end
      check("manager_idle", mgr_cnt, 0);
      send(128, 1, 1'b1, g);
      check("after_rst_midscale", g, 128);

      tick(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/team_06_echo_buffer.md
TEAM_06_ECHO_BUFFER -- requirements
Module: team_06_echo_buffer

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8, sample width in bits; legal values 8 or 16.
REQ-002 SHALL have parameter DEPTH_SAMPLES, default 4096, ring length in samples; power of two, at least 4.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3300_0000, byte address of ring start in SRAM.
REQ-004 SHALL provide clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL provide rst, input, 1, synchronous active-high reset.
REQ-006 SHALL provide sample_in, input, SAMPLE_W, the new audio sample (unsigned, offset-binary).
REQ-007 SHALL provide sample_valid, input, 1, a one-cycle strobe qualifying sample_in.
REQ-008 SHALL provide record, input, 1; when high, samples are written to the ring.
REQ-009 SHALL provide offset, input, 12, the requested delay in samples.
REQ-010 SHALL provide audio_out, output, SAMPLE_W, the output sample.
REQ-011 SHALL provide out_valid, output, 1, a one-cycle strobe qualifying audio_out.
REQ-012 SHALL provide overrun, output, 1, a sticky flag set when a sample is dropped.
REQ-013 SHALL provide bus_wdata, output, 32, write data to the wishbone manager.
REQ-014 SHALL provide bus_adr, output, 32, byte address to the manager.
REQ-015 SHALL provide bus_sel, output, 4, byte-lane select to the manager.
REQ-016 SHALL provide bus_write, output, 1, the write request.
REQ-017 SHALL provide bus_read, output, 1, the read request.
REQ-018 SHALL provide bus_busy, input, 1, the manager busy indication.
REQ-019 SHALL provide bus_rdata, input, 32, read data from the manager.

Function
REQ-020 SHALL pack SPW = 32/SAMPLE_W samples per word: sample index i occupies word i/SPW at byte address BASE_ADDR + 4*(i/SPW), in lane i%SPW (lane 0 = bits [SAMPLE_W-1:0]).
REQ-021 SHALL run FSM IDLE -> (WR_REQ -> WR_WAIT if record) -> RD_REQ -> RD_WAIT -> OUT -> IDLE, leaving IDLE only when sample_valid is high.
REQ-022 SHALL latch sample_in and the effective offset in IDLE on sample_valid; both stay stable for the whole transaction.
REQ-023 SHALL clamp the effective offset to the range 1 to DEPTH_SAMPLES-1 (offset 0 reads as 1; larger values read as DEPTH_SAMPLES-1).
REQ-024 SHALL, in the REQ states, hold the request high with stable adr/sel/wdata until bus_busy is sampled high, then drop it; the WAIT states exit on the first cycle bus_busy is low.
REQ-025 SHALL drive on writes: bus_sel = one-hot lane mask, and bus_wdata = sample replicated across all lanes.
REQ-026 SHALL read index (wr_ptr - eff_offset) mod DEPTH_SAMPLES with bus_sel = 4'hF, and capture bus_rdata lane (rd_idx%SPW) on RD_WAIT exit.
REQ-027 SHALL advance wr_ptr mod DEPTH_SAMPLES after the write completes; the pointer wraps from DEPTH_SAMPLES-1 to 0.
REQ-028 SHALL, with record low, skip the write and leave wr_ptr unchanged (frozen loop replay).
REQ-029 SHALL keep a saturating fill count (max DEPTH_SAMPLES), incremented per write; if fill < eff_offset, the delayed sample SHALL be the midscale value 2^(SAMPLE_W-1) and no SRAM read is issued (RD states skipped).
REQ-030 SHALL, in OUT, register audio_out and pulse out_valid for exactly one cycle.
REQ-031 SHALL drop any sample_valid that arrives outside IDLE and set overrun (cleared only by reset).
REQ-032 SHALL keep bus_write and bus_read mutually exclusive and never both high.

Reset
REQ-033 SHALL, on rst high at a clock edge, force: state IDLE, wr_ptr 0, fill 0, audio_out midscale, out_valid 0, overrun 0, and all bus_* outputs 0.
REQ-034 SHALL, on reset mid-transaction, abandon the transaction with no completion pulse; the manager's residual busy is ignored until the next sample_valid.

Configuration
REQ-035 SHALL, with TEAM_06_ECHO_MIX_EN defined, set audio_out = clamp(sample + delayed - midscale, 0, 2^SAMPLE_W-1), computed at SAMPLE_W+2 bits signed.
REQ-036 SHALL, without TEAM_06_ECHO_MIX_EN, set audio_out = delayed sample, with no adder synthesized.

Verification
REQ-037 Bench SHALL cover: SAMPLE_W=8, offset=3, record=1; feed samples 10,20,30,40,50 -> first three outputs 128 (midscale), then 10, 20.
REQ-038 Bench SHALL cover: SAMPLE_W=8, 5th write -> bus_adr = BASE_ADDR+4, bus_sel = 4'b0001, bus_wdata = {4{sample}}.
REQ-039 Bench SHALL cover: DEPTH_SAMPLES=8, write 9 samples -> wr_ptr wraps to 1 and word 0 lane 0 is overwritten.
REQ-040 Bench SHALL cover: offset=0 -> behaves as offset 1; offset=4095 with DEPTH_SAMPLES=8 -> behaves as offset 7.
REQ-041 Bench SHALL cover: second sample_valid while bus_busy is held 5 cycles -> sample dropped, overrun=1, exactly one out_valid.
REQ-042 Bench SHALL cover: MIX_EN, sample 200, delayed 200 -> audio_out 255; rst during RD_WAIT -> bus_read 0 the next cycle and no out_valid.
